mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a request/ack data bus and feeds the MEM/WB register.
// Optional feature macro UNALIGNED_EXC_EN: misaligned LH/LHU/LW/SH/SW raise adel/ades instead of accessing the bus.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_opr2,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_wd,
  input  logic [31:0] ex_wrdata,
  output logic        dbus_req,
  output logic        dbus_wr,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic        wb_mtor,
  output logic [7:0]  wb_aluop,
  output logic [31:0] wb_opr2,
  output logic [31:0] wb_ramdata,
  output logic [31:0] wb_ramaddr,
  output logic [31:0] wb_wrdata,
  output logic        wb_wreg,
  output logic [4:0]  wb_wd,
  output logic        stallreq,
  output logic        adel,
  output logic        ades
);
  localparam logic [7:0] ALU_LB  = 8'he0;
  localparam logic [7:0] ALU_LH  = 8'he1;
  localparam logic [7:0] ALU_LWL = 8'he2;
  localparam logic [7:0] ALU_LW  = 8'he3;
  localparam logic [7:0] ALU_LBU = 8'he4;
  localparam logic [7:0] ALU_LHU = 8'he5;
  localparam logic [7:0] ALU_LWR = 8'he6;
  localparam logic [7:0] ALU_SB  = 8'he8;
  localparam logic [7:0] ALU_SH  = 8'he9;
  localparam logic [7:0] ALU_SWL = 8'hea;
  localparam logic [7:0] ALU_SW  = 8'heb;
  localparam logic [7:0] ALU_SWR = 8'hee;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state_reg, state_next;

  logic        is_load, is_store, is_mem;
  logic        err_ld, err_st, addr_err, issue;
  logic [1:0]  off;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  // Copy of the issued instruction; EX may be replaced by the time ack arrives.
  logic [31:0] addr_reg, opr2_reg, wrdata_reg;
  logic [7:0]  aluop_reg;
  logic        wreg_reg, flush_seen_reg;
  logic [4:0]  wd_reg;

  assign off       = ex_addr[1:0];
  assign is_mem    = is_load | is_store;
  assign addr_err  = err_ld | err_st;
  assign dbus_addr = {addr_reg[31:2], 2'b00};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (ex_aluop)
      ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_LWL, ALU_LWR: is_load = 1'b1;
      ALU_SB, ALU_SH, ALU_SW, ALU_SWL, ALU_SWR:                   is_store = 1'b1;
      default: ;
    endcase
  end

  // Byte-lane placement of store data; SH on an odd address gets no enables.
  always_comb begin
    be_fmt    = 4'b0000;
    wdata_fmt = 32'h0;
    case (ex_aluop)
      ALU_SB: begin
        be_fmt    = 4'b0001 << off;
        wdata_fmt = {4{ex_opr2[7:0]}};
      end
      ALU_SH: begin
        be_fmt    = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
        wdata_fmt = {2{ex_opr2[15:0]}};
      end
      ALU_SW: begin
        be_fmt    = 4'b1111;
        wdata_fmt = ex_opr2;
      end
      ALU_SWL: begin
        case (off)
          2'b00:   begin be_fmt = 4'b0001; wdata_fmt = {24'h0, ex_opr2[31:24]}; end
          2'b01:   begin be_fmt = 4'b0011; wdata_fmt = {16'h0, ex_opr2[31:16]}; end
          2'b10:   begin be_fmt = 4'b0111; wdata_fmt = {8'h0, ex_opr2[31:8]}; end
          default: begin be_fmt = 4'b1111; wdata_fmt = ex_opr2; end
        endcase
      end
      ALU_SWR: begin
        case (off)
          2'b00:   begin be_fmt = 4'b1111; wdata_fmt = ex_opr2; end
          2'b01:   begin be_fmt = 4'b1110; wdata_fmt = {ex_opr2[23:0], 8'h0}; end
          2'b10:   begin be_fmt = 4'b1100; wdata_fmt = {ex_opr2[15:0], 16'h0}; end
          default: begin be_fmt = 4'b1000; wdata_fmt = {ex_opr2[7:0], 24'h0}; end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    stallreq   = 1'b0;
    if (state_reg == IDLE) begin
      issue    = !rst && ex_valid && is_mem && !flush && !addr_err;
      stallreq = issue;
      if (issue) state_next = BUSY;
    end else begin
      stallreq = !rst && !dbus_ack;
      if (dbus_ack) state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req       <= 1'b0;
      dbus_wr        <= 1'b0;
      dbus_be        <= 4'b0000;
      dbus_wdata     <= 32'h0;
      addr_reg       <= 32'h0;
      opr2_reg       <= 32'h0;
      wrdata_reg     <= 32'h0;
      aluop_reg      <= 8'h0;
      wreg_reg       <= 1'b0;
      wd_reg         <= 5'h0;
      flush_seen_reg <= 1'b0;
      wb_valid       <= 1'b0;
      wb_mtor        <= 1'b0;
      wb_aluop       <= 8'h0;
      wb_opr2        <= 32'h0;
      wb_ramdata     <= 32'h0;
      wb_ramaddr     <= 32'h0;
      wb_wrdata      <= 32'h0;
      wb_wreg        <= 1'b0;
      wb_wd          <= 5'h0;
    end else if (state_reg == IDLE) begin
      if (issue) begin
        dbus_req       <= 1'b1;
        dbus_wr        <= is_store;
        dbus_be        <= be_fmt;
        dbus_wdata     <= wdata_fmt;
        addr_reg       <= ex_addr;
        opr2_reg       <= ex_opr2;
        wrdata_reg     <= ex_wrdata;
        aluop_reg      <= ex_aluop;
        wreg_reg       <= ex_wreg;
        wd_reg         <= ex_wd;
        flush_seen_reg <= 1'b0;
      end else begin
        // Non-memory op, bubble, flushed slot or address error: one-cycle pass-through.
        wb_valid   <= ex_valid && !flush;
        wb_mtor    <= 1'b0;
        wb_aluop   <= ex_aluop;
        wb_opr2    <= ex_opr2;
        wb_ramdata <= 32'h0;
        wb_ramaddr <= ex_addr;
        wb_wrdata  <= ex_wrdata;
        wb_wreg    <= ex_valid && !flush && ex_wreg && !addr_err;
        wb_wd      <= ex_wd;
      end
    end else begin
      if (flush) flush_seen_reg <= 1'b1;
      if (dbus_ack) begin
        dbus_req       <= 1'b0;
        flush_seen_reg <= 1'b0;
        wb_valid       <= !(flush_seen_reg || flush);
        wb_mtor        <= !dbus_wr;
        wb_aluop       <= aluop_reg;
        wb_opr2        <= opr2_reg;
        wb_ramdata     <= dbus_rdata;
        wb_ramaddr     <= addr_reg;
        wb_wrdata      <= wrdata_reg;
        wb_wreg        <= wreg_reg && !(flush_seen_reg || flush);
        wb_wd          <= wd_reg;
      end
    end
  end

`ifdef UNALIGNED_EXC_EN
  assign err_ld = ((ex_aluop == ALU_LH || ex_aluop == ALU_LHU) && off[0]) ||
                  (ex_aluop == ALU_LW && off != 2'b00);
  assign err_st = (ex_aluop == ALU_SH && off[0]) || (ex_aluop == ALU_SW && off != 2'b00);

  // Exception flags travel with the MEM/WB register and change only when it loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      adel <= 1'b0;
      ades <= 1'b0;
    end else if (state_reg == IDLE && !issue) begin
      adel <= ex_valid && !flush && err_ld;
      ades <= ex_valid && !flush && err_st;
    end else if (state_reg == BUSY && dbus_ack) begin
      adel <= 1'b0;
      ades <= 1'b0;
    end
  end
`else
  assign err_ld = 1'b0;
  assign err_st = 1'b0;
  assign adel   = 1'b0;
  assign ades   = 1'b0;
`endif

endmodule
